// File: rtl/ks_i2s_tx.sv
// I2S transmitter: a 2-entry sample FIFO feeding a mono-to-stereo serializer with frame tick.
// Define KS_I2S_TX_LJ_EN for left-justified output (no 1-bit delay after the lrck edge).
module ks_i2s_tx #(
    parameter int SAMPLE_W  = 16,
    parameter int BCLK_DIV  = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic                clk,
    input  logic                aclr_n,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic                sample_valid,
    output logic                sample_ready,
    input  logic                underrun_clr,
    output logic                underrun,
    output logic                frame_strobe,
    output logic                bclk,
    output logic                lrck,
    output logic                sdata
);

    localparam int DW = $clog2(BCLK_DIV);
    localparam int PW = $clog2(2 * SLOT_BITS);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);
    localparam logic [PW-1:0] POS_LAST = PW'(2 * SLOT_BITS - 1);
    localparam logic [PW-1:0] SLOT_LEN = PW'(SLOT_BITS);

    logic [DW-1:0]       div;
    logic [PW-1:0]       pos;
    logic [SAMPLE_W-1:0] out_reg;
    logic [SAMPLE_W-1:0] fifo_mem [2];
    logic                wr_ptr;
    logic                rd_ptr;
    logic [1:0]          count;

    logic                fall;
    logic                frame_start;
    logic                push;
    logic                pop;
    logic [PW-1:0]       pos_nxt;
    logic [PW-1:0]       slot_idx;
    logic                lrck_nxt;
    logic                sdata_nxt;
    logic [SAMPLE_W-1:0] out_nxt;
    logic [1:0]          count_nxt;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        fall        = bclk && (div == DIV_LAST);
        pos_nxt     = (pos == POS_LAST) ? '0 : pos + 1'b1;
        frame_start = fall && (pos_nxt == '0);
        push        = sample_valid && sample_ready;
        pop         = frame_start && (count != 2'd0);
        out_nxt     = pop ? fifo_mem[rd_ptr] : out_reg;
        lrck_nxt    = (pos_nxt >= SLOT_LEN);
        slot_idx    = lrck_nxt ? pos_nxt - SLOT_LEN : pos_nxt;

        // The bit shown at a position is taken from the freshly loaded word at frame start.
        sdata_nxt = 1'b0;
        for (int i = 0; i < SAMPLE_W; i++) begin
`ifdef KS_I2S_TX_LJ_EN
            if (slot_idx == PW'(SAMPLE_W - 1 - i)) sdata_nxt = out_nxt[i];
`else
            if (slot_idx == PW'(SAMPLE_W - i)) sdata_nxt = out_nxt[i];
`endif
        end

        unique case ({push, pop})
            2'b10:   count_nxt = count + 2'd1;
            2'b01:   count_nxt = count - 2'd1;
            default: count_nxt = count;
        endcase
    end

    // NOTE: FIFO storage is not reset; only pointers and count define its contents.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= sample;
    end

    always_ff @(posedge clk) begin
        if (!aclr_n) begin
            div          <= '0;
            bclk         <= 1'b0;
            pos          <= POS_LAST;
            lrck         <= 1'b0;
            sdata        <= 1'b0;
            frame_strobe <= 1'b0;
            underrun     <= 1'b0;
            out_reg      <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            sample_ready <= 1'b1;
        end else begin
            frame_strobe <= frame_start;
            if (div == DIV_LAST) begin
                div  <= '0;
                bclk <= ~bclk;
            end else begin
                div <= div + 1'b1;
            end

            if (fall) begin
                pos     <= pos_nxt;
                lrck    <= lrck_nxt;
                sdata   <= sdata_nxt;
                out_reg <= out_nxt;
            end

            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count        <= count_nxt;
            sample_ready <= (count_nxt != 2'd2);

            // A new underrun outranks a simultaneous clear.
            if (frame_start && (count == 2'd0)) underrun <= 1'b1;
            else if (underrun_clr)              underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ks_i2s_tx.sv
// Bench for ks_i2s_tx: directed stimulus queues each frame's expected word; a monitor
// deserializes every complete frame and compares it against the queue head.
module tb_ks_i2s_tx;

    logic        clk = 1'b0;
    logic        aclr_n;
    logic [15:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        underrun_clr;
    logic        underrun;
    logic        frame_strobe;
    logic        bclk;
    logic        lrck;
    logic        sdata;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] sb_q [$];

`ifdef KS_I2S_TX_LJ_EN
    localparam int OFF = 0;
`else
    localparam int OFF = 1;
`endif

    ks_i2s_tx dut (
        .clk          (clk),
        .aclr_n       (aclr_n),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .underrun_clr (underrun_clr),
        .underrun     (underrun),
        .frame_strobe (frame_strobe),
        .bclk         (bclk),
        .lrck         (lrck),
        .sdata        (sdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected sdata per bit position p (bit p of the result) for a given word.
    function automatic logic [63:0] exp_frame(input logic [15:0] w);
        logic [63:0] f;
        f = '0;
        for (int p = 0; p < 64; p++) begin
            int s;
            s = p % 32;
            if (s >= OFF && s < OFF + 16) f[p] = w[15 - (s - OFF)];
        end
        return f;
    endfunction

    // Monitor: capture bits on every bclk fall, close the frame at the next strobe.
    logic [63:0] cap;
    logic [63:0] lr;
    int          pos;
    int          cyc;
    bit          open_frame = 1'b0;
    logic        prev_bclk  = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (!aclr_n) begin
                if (open_frame && sb_q.size() > 0) void'(sb_q.pop_front());
                open_frame = 1'b0;
                prev_bclk  = 1'b0;
            end else begin
                cyc++;
                if (prev_bclk && !bclk) begin
                    if (frame_strobe) begin
                        if (open_frame) begin
                            logic [15:0] w;
                            if (sb_q.size() == 0) begin
                                vectors++;
                                miscompares++;
                                $display("FAIL frame_unexpected: got frame with no expected word queued");
                            end else begin
                                w = sb_q.pop_front();
                                check("frame_bits", 64'(pos), 64'd63);
                                check("frame_sdata", cap, exp_frame(w));
                                check("frame_lrck", lr, 64'hFFFF_FFFF_0000_0000);
                                check("frame_len", 64'(cyc), 64'd512);
                            end
                        end
                        open_frame = 1'b1;
                        pos = 0;
                        cyc = 0;
                        cap = '0;
                        lr  = '0;
                        cap[0] = sdata;
                        lr[0]  = lrck;
                    end else if (open_frame) begin
                        pos++;
                        if (pos < 64) begin
                            cap[pos] = sdata;
                            lr[pos]  = lrck;
                        end
                    end
                end
                prev_bclk = bclk;
            end
        end
    end

    task automatic wait_frame(input logic [15:0] exp_word);
        for (int i = 0; i < 1100; i++) begin
            @(negedge clk);
            if (frame_strobe) begin
                sb_q.push_back(exp_word);
                return;
            end
        end
        vectors++;
        miscompares++;
        $display("FAIL frame_timeout: got no frame_strobe within 1100 clk, expected one");
    endtask

    task automatic strobe_after_release(input string name);
        int n;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n++;
            if (i == 0) check({name, "_ready"}, 64'(sample_ready), 64'd1);
            if (frame_strobe) break;
        end
        check({name, "_strobe_lat"}, 64'(n), 64'd8);
        sb_q.push_back(16'h0000);
        check({name, "_underrun"}, 64'(underrun), 64'd1);
    endtask

    initial begin
        aclr_n       = 1'b0;
        sample       = '0;
        sample_valid = 1'b0;
        underrun_clr = 1'b0;

        // Reset and first frame on an empty FIFO.
        repeat (3) @(negedge clk);
        check("rst_bclk",     64'(bclk),         64'd0);
        check("rst_lrck",     64'(lrck),         64'd0);
        check("rst_sdata",    64'(sdata),        64'd0);
        check("rst_strobe",   64'(frame_strobe), 64'd0);
        check("rst_underrun", 64'(underrun),     64'd0);
        aclr_n = 1'b1;
        strobe_after_release("init");

        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("underrun_clr", 64'(underrun), 64'd0);

        // Single word A5C3.
        check("ready_a5c3", 64'(sample_ready), 64'd1);
        sample = 16'hA5C3;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        wait_frame(16'hA5C3);
        check("underrun_stays_clear", 64'(underrun), 64'd0);

        // Fill the FIFO, then hold a third word off until the next pop.
        sample = 16'h8001;
        sample_valid = 1'b1;
        @(negedge clk);
        check("ready_one", 64'(sample_ready), 64'd1);
        sample = 16'h7FFE;
        @(negedge clk);
        check("ready_full", 64'(sample_ready), 64'd0);
        sample = 16'h1234;
        wait_frame(16'h8001);
        check("ready_after_pop", 64'(sample_ready), 64'd1);
        @(negedge clk);
        sample_valid = 1'b0;
        wait_frame(16'h7FFE);
        wait_frame(16'h1234);
        check("underrun_full_run", 64'(underrun), 64'd0);

        // Empty FIFO: word repeats, underrun sets, and a coincident clear loses.
        wait_frame(16'h1234);
        check("underrun_set", 64'(underrun), 64'd1);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("underrun_clr2", 64'(underrun), 64'd0);
        repeat (510) @(negedge clk);
        underrun_clr = 1'b1;
        @(negedge clk);
        underrun_clr = 1'b0;
        check("strobe_align", 64'(frame_strobe), 64'd1);
        check("underrun_set_wins", 64'(underrun), 64'd1);
        sb_q.push_back(16'h1234);

        // Queue a word, then reset at p=20: the word must be flushed.
        sample = 16'h5A5A;
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        repeat (159) @(negedge clk);
        aclr_n = 1'b0;
        @(negedge clk);
        check("mid_rst_bclk",     64'(bclk),         64'd0);
        check("mid_rst_lrck",     64'(lrck),         64'd0);
        check("mid_rst_sdata",    64'(sdata),        64'd0);
        check("mid_rst_strobe",   64'(frame_strobe), 64'd0);
        check("mid_rst_underrun", 64'(underrun),     64'd0);
        aclr_n = 1'b1;
        strobe_after_release("post_rst");
        wait_frame(16'h0000);

        repeat (4) @(negedge clk);
        check("sb_pending", 64'(sb_q.size()), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ks_i2s_tx.md
Name: ks_i2s_tx

Overview:
- Audio output serializer for the synthX voice path; consumes the 16-bit sample stream produced by the Karplus-Strong voice and drives a stereo I2S DAC.
- Mono sample duplicated onto left and right slots.
- Generates the `frame_strobe` pulse, usable by the synth as its sample-rate tick.
- Buffers samples in a 2-entry FIFO with a valid/ready handshake and flags underrun.

Parameters:
- `SAMPLE_W`, 16, sample width in bits; must be ≤ 31.
- `BCLK_DIV`, 4, `clk` cycles per bclk half-period; must be ≥ 2.
- `SLOT_BITS`, 32, bclk periods per channel slot; frame is 2*`SLOT_BITS`; must be > `SAMPLE_W`.

Ports:
- `clk`  in  1  system clock
- `aclr_n`  in  1  reset, synchronous, active-low
- `sample`  in  SAMPLE_W  signed two's-complement audio sample
- `sample_valid`  in  1  sample offered this cycle
- `sample_ready`  out  1  FIFO can accept; transfer when valid&&ready
- `underrun_clr`  in  1  clears sticky underrun flag
- `underrun`  out  1  sticky: frame start found FIFO empty
- `frame_strobe`  out  1  one-clk pulse at each frame start
- `bclk`  out  1  I2S bit clock
- `lrck`  out  1  word select, 0 = left, 1 = right
- `sdata`  out  1  serial data, MSB first

Behaviour:
- Reset: single clock, `clk`; `aclr_n` sampled only on rising `clk`.
  - While `aclr_n`=0 at a clk edge: `bclk`=0, `lrck`=0, `sdata`=0, `frame_strobe`=0, `underrun`=0, FIFO emptied, output register=0, divider=0.
  - Bit position = 2*`SLOT_BITS`-1, so the first falling-edge event after reset starts a frame at position 0.
  - `sample_ready`=1 from the first cycle after reset.
  - Reset mid-frame aborts serialization immediately; no partial word resumes.
- Divider: counts 0..`BCLK_DIV`-1.
  - On terminal count, `bclk` toggles and the divider wraps.
  - A 1→0 toggle is a "fall event".
  - bclk period = 2*`BCLK_DIV` clk cycles.
- Frame state: bit position p counts 0..2*`SLOT_BITS`-1 and advances by 1 (wrapping) on each fall event. On the same clk edge as the fall event, all outputs update registered:
  - `lrck` = (p ≥ `SLOT_BITS`).
  - Slot-relative index s = p mod `SLOT_BITS`. Standard I2S with 1-bit delay: `sdata` = out_reg[`SAMPLE_W`-s] for 1 ≤ s ≤ `SAMPLE_W`, else 0.
  - At p=0, first the frame-start action runs, then `sdata` for p=0 uses the new out_reg (value 0 since s=0).
- Frame start action (p=0 fall event):
  - If the FIFO is non-empty: pop the head into out_reg.
  - If empty: out_reg holds its previous value (repeat last sample) and `underrun` is set.
  - `frame_strobe`=1 for exactly that clk cycle.
  - The right slot reuses out_reg unchanged.
- FIFO: 2 entries.
  - `sample_ready` = not full, registered from the current count.
  - Push on `sample_valid`&&`sample_ready`; push while full is impossible by handshake.
  - Simultaneous push and pop on a full FIFO: pop occurs and the push is not accepted (ready was 0).
  - On an empty FIFO, the pop sees the FIFO empty (underrun) and the push lands.
  - Push and pop at count 1 leave the count at 1.
- Underrun flag:
  - Stays set until `underrun_clr`=1.
  - If a set and a clear coincide, the set wins.
- Latency: an accepted sample into an empty FIFO appears as MSB on `sdata` at the second fall event after the next frame start.

Optional Feature:
- Macro `KS_I2S_TX_LJ_EN`.
- Defined: left-justified format, no 1-bit delay. `sdata` = out_reg[`SAMPLE_W`-1-s] for 0 ≤ s < `SAMPLE_W`, else 0; MSB coincides with the `lrck` edge.
- Undefined: standard I2S as above.
- All other timing is identical.

Test Plan:
1. Reset: hold `aclr_n`=0 for 3 clk, then release.
   - Required: `bclk`/`lrck`/`sdata`/`underrun`=0, `sample_ready`=1.
   - First `frame_strobe` exactly 2*`BCLK_DIV`=8 clk after release (first fall event); `underrun`=1 after it (FIFO empty).
2. Push 16'hA5C3 before the first frame start with default parameters.
   - Required: left slot `sdata` bits at p=1..16 = 1010010111000011, p=17..31 = 0.
   - Right slot p=33..48 carries the same word.
   - `lrck` toggles at p=32; frame = 512 clk.
3. Push 16'h8001 and 16'h7FFE back-to-back.
   - Required: `sample_ready` drops after the second push.
   - Third `sample_valid` is held off until the next `frame_strobe`.
   - Words emitted in order on consecutive frames.
4. Underrun: after one sample 16'h1234, push nothing.
   - Required: next frame repeats 16'h1234 and `underrun`=1.
   - Assert `underrun_clr` on the cycle of a new underrun frame start: `underrun` stays 1.
5. Assert `aclr_n`=0 at p=20 mid-left-slot.
   - Required: outputs are 0 on the next clk, FIFO is empty, and the next frame restarts at p=0 with out_reg=0.
6. With `KS_I2S_TX_LJ_EN` defined, push 16'hA5C3.
   - Required: `sdata` at p=0..15 = 1010010111000011; p=16 carries 0.
